blockade_tone_bank: RTL and testbench
=====================================

BLOCKADE_TONE_BANK -- requirements
Module: blockade_tone_bank

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent tone channels, legal range 1..8.
REQ-002 Parameter CNT_W, default 8: width of each channel's reload value and period counter.
REQ-003 Parameter PRESCALE, default 191: clk cycles per tone tick, legal range 2..65535.
REQ-004 Parameter AMP, default 30000: peak square-wave amplitude, legal range 1..32767.
REQ-005 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port wr, input, 1: register write strobe, sampled each clk.
REQ-008 Port wr_sel, input, 1: register select; 0 = reload register, 1 = control register.
REQ-009 Port wr_chan, input, 3: target channel index.
REQ-010 Port wr_data, input, CNT_W: write data; control register uses bits [2:0].
REQ-011 Port tick, output, 1: one-cycle pulse on each prescaler tick.
REQ-012 Port tone_out, output, CHANNELS: per-channel square-wave state.
REQ-013 Port audio, output, signed 16: registered mixed channel output.

Function
REQ-014 Prescaler counts 0..PRESCALE-1 and wraps; tick is high for the single cycle where the count equals PRESCALE-1.
REQ-015 Each channel holds: reload[CNT_W], count[CNT_W], en, vol[1:0], sq.
REQ-016 Control register mapping: bit0 = en; bits[2:1] = vol, a right-shift amount 0..3 applied to AMP.
REQ-017 A write with wr_chan >= CHANNELS is ignored, with no state change.
REQ-018 A reload write updates reload on the next clk edge; count is not altered by the write.
REQ-019 A control write updates en and vol on the next clk edge.
REQ-020 While en=0: count <= reload every cycle, and sq <= 0.
REQ-021 On tick with en=1 and reload != all-ones: if count == all-ones, then count <= reload and sq toggles; otherwise count <= count+1.
REQ-022 Resulting half-period is (2^CNT_W - reload) ticks; reload=0 gives the longest half-period, reload = all-ones - 1 gives 2 ticks.
REQ-023 reload == all-ones is the silent code: count and sq hold, and the channel contributes 0 to audio.
REQ-024 A reload write and an overflow load in the same cycle: count takes the newly written value.
REQ-025 A control write clearing en in the same cycle as a tick: disable wins, so count <= new-cycle reload and sq <= 0.
REQ-026 Channel contribution: en=0 or silent gives 0; otherwise sq=1 gives +(AMP>>vol) and sq=0 gives -(AMP>>vol).
REQ-027 Contributions are summed at full width (>= 19 bits signed).
REQ-028 The sum saturates to +32767 / -32768 and is registered into audio, so audio lags tone_out by exactly 1 clk.
REQ-029 tone_out[i] = sq of channel i, driven directly from the register with no added latency.

Reset
REQ-030 While reset is high: prescaler=0, tick=0, and all reload, count, en, vol and sq = 0.
REQ-031 While reset is high: tone_out=0 and audio=0.
REQ-032 Asserting reset mid-operation clears state immediately, without waiting for a clk edge.
REQ-033 After reset deasserts, the first tick occurs on the PRESCALE-th rising clk edge.
REQ-034 Writes presented while reset is high are discarded.

Verification
REQ-035 Bench overrides: PRESCALE=4, CNT_W=8, CHANNELS=2, AMP=30000 (unless a scenario states otherwise).
REQ-036 Scenario: ch0 reload=0xFC, control=0x01 -> tone_out[0] toggles every 4 ticks (16 clk); audio alternates +30000/-30000, one clk behind tone_out.
REQ-037 Scenario: ch0 control=0x05 (vol=2), ch1 control=0x03 (vol=1), both reload=0xFE -> audio takes only values in {+22500, -22500, +7500, -7500}.
REQ-038 Scenario: ch0 reload=0xFF with en=1 -> tone_out[0] stays 0 and audio stays 0 indefinitely.
REQ-039 Scenario: CHANNELS=2 with AMP=32767, vol=0 and both sq=1 -> audio = +32767 (saturated); with both sq=0 -> audio = -32768.
REQ-040 Scenario: write reload=0xF0 on the same cycle ch0 overflows -> the next count is 0xF0 and the following half-period is 16 ticks.
REQ-041 Scenario: reset pulse mid-tone, asynchronous and between edges -> tone_out, audio and tick read 0 before the next edge; writes to wr_chan=5 are ignored.

Source files
------------

// File: rtl/blockade_tone_bank.sv
// Multi-channel square-wave tone generator sharing one prescaler,
// mixed into a saturated, registered signed 16-bit audio sample.
module blockade_tone_bank #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 191,
  parameter int AMP      = 30000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic                wr_sel,
  input  logic [2:0]          wr_chan,
  input  logic [CNT_W-1:0]    wr_data,
  output logic                tick,
  output logic [CHANNELS-1:0] tone_out,
  output logic signed [15:0]  audio
);

  localparam int PW = $clog2(PRESCALE);
  localparam int SW = 20;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic signed [SW-1:0] MAXV = SW'(32767);
  localparam logic signed [SW-1:0] MINV = -SW'(32768);

  logic [PW-1:0] pre_q, pre_d;

  assign tick  = (pre_q == LAST);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end

  logic signed [SW-1:0] contrib_a [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CNT_W-1:0]     reload_q, reload_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 en_q, en_d, sq_q, sq_d;
    logic [1:0]           vol_q, vol_d;
    logic                 hit;
    logic signed [SW-1:0] mag;

    assign hit = wr && (wr_chan == 3'(g));

    always_comb begin
      reload_d = reload_q;
      en_d     = en_q;
      vol_d    = vol_q;
      count_d  = count_q;
      sq_d     = sq_q;
      if (hit && !wr_sel) reload_d = wr_data;
      if (hit && wr_sel) begin
        en_d  = wr_data[0];
        vol_d = wr_data[2:1];
      end
      // disabling in this cycle overrides any tick activity
      if (!en_q || !en_d) begin
        count_d = reload_d;
        sq_d    = 1'b0;
      end else if (tick && reload_q != ONES) begin
        if (count_q == ONES) begin
          count_d = reload_d;
          sq_d    = !sq_q;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        reload_q <= '0;
        count_q  <= '0;
        en_q     <= 1'b0;
        vol_q    <= 2'd0;
        sq_q     <= 1'b0;
      end else begin
        reload_q <= reload_d;
        count_q  <= count_d;
        en_q     <= en_d;
        vol_q    <= vol_d;
        sq_q     <= sq_d;
      end
    end

    assign mag = SW'(AMP >> vol_q);
    assign contrib_a[g] =
      (!en_q || reload_q == ONES) ? '0 :
      (sq_q ? mag : -mag);
    assign tone_out[g] = sq_q;
  end

  logic signed [SW-1:0] sum;
  logic signed [15:0]   sat;
  logic signed [15:0]   audio_q;

  always_comb begin
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) sum = sum + contrib_a[i];
    if (sum > MAXV)      sat = 16'sh7FFF;
    else if (sum < MINV) sat = 16'sh8000;
    else                 sat = sum[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) audio_q <= '0;
    else       audio_q <= sat;
  end

  assign audio = audio_q;

endmodule

// File: tb/tb_blockade_tone_bank.sv
// Bench for blockade_tone_bank: directed scenarios plus random writes,
// checked every cycle against a tick-level integer model.
module tb_blockade_tone_bank;

  localparam int PRE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0;
  logic        wr_sel = 1'b0;
  logic [2:0]  wr_chan = 3'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        tick, tick2;
  logic [1:0]  tone_out, tone2;
  logic signed [15:0] audio, audio2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int m_pre;
  int m_reload[2], m_count[2], m_en[2], m_vol[2], m_sq[2];
  int m_audio, m_audio2;

  always #5 clk = ~clk;

  blockade_tone_bank #(
    .CHANNELS(2), .CNT_W(8), .PRESCALE(PRE), .AMP(30000)
  ) dut (
    .clk(clk), .reset(reset), .wr(wr), .wr_sel(wr_sel),
    .wr_chan(wr_chan), .wr_data(wr_data), .tick(tick),
    .tone_out(tone_out), .audio(audio)
  );

  blockade_tone_bank #(
    .CHANNELS(2), .CNT_W(8), .PRESCALE(PRE), .AMP(32767)
  ) dut_max (
    .clk(clk), .reset(reset), .wr(wr), .wr_sel(wr_sel),
    .wr_chan(wr_chan), .wr_data(wr_data), .tick(tick2),
    .tone_out(tone2), .audio(audio2)
  );

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d cyc=%0d",
             tag, obs, exp, cyc);
    end
  endtask

  function automatic int clamp(input int s);
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic int contrib(input int c, input int amp);
    int mag;
    if (m_en[c] == 0 || m_reload[c] == 255) return 0;
    mag = amp / (1 << m_vol[c]);
    return (m_sq[c] != 0) ? mag : -mag;
  endfunction

  task automatic model_reset();
    m_pre = 0;
    m_audio = 0;
    m_audio2 = 0;
    for (int c = 0; c < 2; c++) begin
      m_reload[c] = 0; m_count[c] = 0;
      m_en[c] = 0; m_vol[c] = 0; m_sq[c] = 0;
    end
  endtask

  task automatic model_edge();
    int s1, s2, nr, ne, nv;
    bit t;
    s1 = 0;
    s2 = 0;
    for (int c = 0; c < 2; c++) begin
      s1 += contrib(c, 30000);
      s2 += contrib(c, 32767);
    end
    m_audio  = clamp(s1);
    m_audio2 = clamp(s2);
    t = (m_pre == PRE - 1);
    for (int c = 0; c < 2; c++) begin
      nr = m_reload[c];
      ne = m_en[c];
      nv = m_vol[c];
      if (wr && int'(wr_chan) == c) begin
        if (wr_sel) begin
          ne = int'(wr_data[0]);
          nv = int'(wr_data[2:1]);
        end else begin
          nr = int'(wr_data);
        end
      end
      if (m_en[c] == 0 || ne == 0) begin
        m_count[c] = nr;
        m_sq[c] = 0;
      end else if (t && m_reload[c] != 255) begin
        if (m_count[c] == 255) begin
          m_count[c] = nr;
          m_sq[c] = 1 - m_sq[c];
        end else begin
          m_count[c] = m_count[c] + 1;
        end
      end
      m_reload[c] = nr;
      m_en[c] = ne;
      m_vol[c] = nv;
    end
    m_pre = (m_pre + 1) % PRE;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    cyc++;
    #1;
    chk("tick", tick, (m_pre == PRE - 1));
    chk("tone", tone_out, m_sq[0] + 2 * m_sq[1]);
    chk("audio", audio, m_audio);
    chk("audio_amp_max", audio2, m_audio2);
  endtask

  task automatic wr_reg(input bit sel, input int ch, input int d);
    wr = 1'b1;
    wr_sel = sel;
    wr_chan = 3'(ch);
    wr_data = 8'(d);
    step();
    wr = 1'b0;
  endtask

  // assert reset between edges and check outputs clear before any edge
  task automatic async_reset();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_tick", tick, 0);
    chk("rst_tone", tone_out, 0);
    chk("rst_audio", audio, 0);
    chk("rst_audio_max", audio2, 0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    int q[$];
    int toggles, prev, w, gap;
    bit hi, lo, found, inset;

    model_reset();
    #2;
    chk("por_tick", tick, 0);
    chk("por_tone", tone_out, 0);
    chk("por_audio", audio, 0);
    step();
    reset = 1'b0;

    step();
    step();
    chk("first_tick_early", tick, 0);
    step();
    chk("first_tick", tick, 1);

    // half-period of 4 ticks on ch0
    wr_reg(0, 0, 8'hFC);
    wr_reg(1, 0, 8'h01);
    prev = int'(tone_out[0]);
    for (int i = 0; i < 64; i++) begin
      step();
      if (int'(tone_out[0]) != prev) q.push_back(cyc);
      prev = int'(tone_out[0]);
    end
    chk("s036_toggles", q.size(), 4);
    for (int i = 1; i < q.size(); i++)
      chk("s036_gap", q[i] - q[i-1], 16);

    async_reset();
    wr_reg(0, 0, 8'hFE);
    wr_reg(1, 0, 8'h05);
    wr_reg(0, 1, 8'hFE);
    wr_reg(1, 1, 8'h03);
    step();
    for (int i = 0; i < 60; i++) begin
      step();
      inset = (audio == 22500 || audio == -22500 ||
               audio == 7500 || audio == -7500);
      chk("s037_set", inset, 1);
    end

    async_reset();
    wr_reg(0, 0, 8'hFF);
    wr_reg(1, 0, 8'h01);
    for (int i = 0; i < 40; i++) begin
      step();
      chk("s038_tone", tone_out[0], 0);
      chk("s038_audio", audio, 0);
    end

    async_reset();
    wr_reg(0, 0, 8'hFE);
    wr_reg(0, 1, 8'hFE);
    wr_reg(1, 0, 8'h01);
    wr_reg(1, 1, 8'h01);
    hi = 0;
    lo = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (audio2 == 16'sh7FFF) hi = 1;
      if (audio2 == -16'sh8000) lo = 1;
    end
    chk("s039_sat_pos", hi, 1);
    chk("s039_sat_neg", lo, 1);

    // reload write on the overflow edge of ch0
    async_reset();
    wr_reg(0, 0, 8'hFC);
    wr_reg(1, 0, 8'h01);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_count[0] == 255 && m_pre == PRE - 1) found = 1;
      else step();
    end
    chk("s040_reach_overflow", found, 1);
    prev = int'(tone_out[0]);
    wr_reg(0, 0, 8'hF0);
    chk("s040_toggle_on_write", tone_out[0], 1 - prev);
    w = cyc;
    prev = int'(tone_out[0]);
    gap = -1;
    for (int i = 0; i < 200 && gap < 0; i++) begin
      step();
      if (int'(tone_out[0]) != prev) gap = cyc - w;
    end
    chk("s040_half_period", gap, 64);

    // writes during reset and to nonexistent channel are dropped
    step();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("s041_tick", tick, 0);
    chk("s041_tone", tone_out, 0);
    chk("s041_audio", audio, 0);
    wr = 1'b1;
    wr_sel = 1'b1;
    wr_chan = 3'd0;
    wr_data = 8'h01;
    step();
    step();
    wr = 1'b0;
    reset = 1'b0;
    wr_reg(0, 5, 8'hFE);
    wr_reg(1, 5, 8'h01);
    for (int i = 0; i < 40; i++) begin
      step();
      chk("s041_tone_idle", tone_out, 0);
      chk("s041_audio_idle", audio, 0);
    end

    // random register traffic, including invalid channels
    for (int i = 0; i < 400; i++) begin
      wr = ($urandom_range(0, 3) == 0);
      wr_sel = 1'($urandom_range(0, 1));
      wr_chan = 3'($urandom_range(0, 3));
      wr_data = wr_sel ? 8'($urandom_range(0, 7))
                       : 8'($urandom_range(8'hF0, 8'hFF));
      step();
    end
    wr = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
